me_control: RTL and testbench

ME_CONTROL -- requirements
Module: me_control

---
 rtl/me_control_if.sv | 47 ++++
 rtl/me_control.sv | 150 +++++++++++++++
 tb/tb_me_control.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/me_control_if.sv
// me_control_if: start request plus the address, mux, PE and status bus of
// the full-search motion-estimation controller.
//
// Signals
//   start               request to begin a search (into the controller)
//   AddressR [7:0]      reference-memory pixel address
//   AddressS1/S2 [9:0]  search-memory addresses, left/right half
//   S1S2mux [15:0]      per-PE data select, 1 = S1
//   NewDist [15:0]      per-PE accumulator clear / new distance
//   CompStart           comparator enable
//   PEready [15:0]      one-hot finished-distance flag
//   VectorX/Y [3:0]     motion vector of the ready PE
//   busy, done          search status
//
// Modports
//   master  controller side
//   slave   memory / PE-array side
interface me_control_if;
  logic        start;
  logic [7:0]  AddressR;
  logic [9:0]  AddressS1;
  logic [9:0]  AddressS2;
  logic [15:0] S1S2mux;
  logic [15:0] NewDist;
  logic        CompStart;
  logic [15:0] PEready;
  logic [3:0]  VectorX;
  logic [3:0]  VectorY;
  logic        busy;
  logic        done;

  modport master (
    input  start,
    output AddressR, AddressS1, AddressS2,
    output S1S2mux, NewDist, CompStart,
    output PEready, VectorX, VectorY,
    output busy, done
  );

  modport slave (
    output start,
    input  AddressR, AddressS1, AddressS2,
    input  S1S2mux, NewDist, CompStart,
    input  PEready, VectorX, VectorY,
    input  busy, done
  );
endinterface

// File: rtl/me_control.sv
// me_control: sequencer for a 16-PE full-search motion estimator
// (16x16 reference block, 32x32 search window).
//
// Ports
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    me_control_if.master (start in; addresses, PE control,
//          motion vector, busy and done out)
//
// One 13-bit counter walks p (vertical offset), r (row), c (column).
// RUN covers 4096 cycles; DRAIN flushes the last row of 16 PEs.
// Every output is a pure decode of state_q/cnt_q.
module me_control (
  input  logic         clock,
  input  logic         reset,
  me_control_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [12:0] RUN_LAST   = 13'd4095;
  localparam logic [12:0] DRAIN_LAST = 13'd4111;
  localparam logic [12:0] COMP_FIRST = 13'd256;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [12:0] cnt_q;
  logic [12:0] cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 13'd1;
        if (cnt_q == RUN_LAST) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 13'd1;
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [3:0]  p;
  logic [3:0]  r;
  logic [3:0]  c;
  logic [7:0]  k;
  logic        in_run;
  logic        in_drain;
  logic        in_done;
  logic [4:0]  row_s1;
  logic [4:0]  row_s2;
  logic        k_lo;
  logic [15:0] k_hot;
  logic [15:0] c_hot;
  logic [15:0] therm;

  assign p        = cnt_q[11:8];
  assign r        = cnt_q[7:4];
  assign c        = cnt_q[3:0];
  assign k        = cnt_q[7:0];
  assign in_run   = (state_q == S_RUN);
  assign in_drain = (state_q == S_DRAIN);
  assign in_done  = (state_q == S_DONE);

  // S2 row trails S1 by one, wrapping mod 32
  assign row_s1 = {1'b0, r} + {1'b0, p};
  assign row_s2 = row_s1 - 5'd1;

  // k < 16: first pixel of PE k's block row
  assign k_lo  = (k[7:4] == 4'd0);
  assign k_hot = 16'd1 << k[3:0];
  assign c_hot = 16'd1 << c;
  // bits 0..c set
  assign therm = 16'hFFFF >> (4'd15 - c);

  always_comb begin
    bus.AddressR  = '0;
    bus.AddressS1 = '0;
    bus.AddressS2 = '0;
    bus.S1S2mux   = '0;
    bus.NewDist   = '0;
    bus.CompStart = 1'b0;
    bus.PEready   = '0;
    bus.VectorX   = '0;
    bus.VectorY   = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    unique case (1'b1)
      in_run: begin
        bus.AddressR  = k;
        bus.AddressS1 = {row_s1, 1'b0, c};
        bus.AddressS2 = {row_s2, 1'b1, c};
        bus.S1S2mux   = therm;
        bus.NewDist   = k_lo ? k_hot : 16'd0;
        bus.CompStart = (cnt_q >= COMP_FIRST);
        bus.busy      = 1'b1;
        // PE k finishes the previous offset p-1
        if (k_lo && (p != 4'd0)) begin
          bus.PEready = k_hot;
          bus.VectorX = k[3:0];
          bus.VectorY = p - 4'd1;
        end
      end
      in_drain: begin
        bus.AddressS2 = {5'd30, 1'b1, c};
        bus.CompStart = 1'b1;
        bus.busy      = 1'b1;
        bus.PEready   = c_hot;
        bus.VectorX   = c;
        bus.VectorY   = 4'd15;
      end
      in_done: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_me_control.sv
// tb_me_control: self-checking bench for me_control.
// Scoreboard of expected output vectors, one task per scenario.
module tb_me_control;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  me_control_if bus();

  me_control dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;

  logic [86:0] sb_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [86:0] obs();
    return {bus.AddressR, bus.AddressS1, bus.AddressS2,
            bus.S1S2mux, bus.NewDist, bus.PEready,
            bus.CompStart, bus.VectorX, bus.VectorY,
            bus.busy, bus.done};
  endfunction

  // expected outputs n cycles after the start edge
  // (0..4095 RUN, 4096..4111 DRAIN, 4112 DONE, then IDLE)
  function automatic logic [86:0] exp_at(int n);
    logic [7:0]  ar;
    logic [9:0]  s1, s2;
    logic [15:0] mux, nd, rdy;
    logic        cs, bz, dn;
    logic [3:0]  vx, vy;
    int p, r, c, k;
    ar = 0; s1 = 0; s2 = 0; mux = 0; nd = 0; rdy = 0;
    cs = 0; bz = 0; dn = 0; vx = 0; vy = 0;
    if (n >= 0 && n < 4096) begin
      p = n / 256;
      r = (n / 16) % 16;
      c = n % 16;
      k = n % 256;
      ar  = 8'(k);
      s1  = 10'(((r + p) % 32) * 32 + c);
      s2  = 10'(((r + p + 31) % 32) * 32 + 16 + c);
      mux = 16'((1 << (c + 1)) - 1);
      if (k < 16) nd = 16'(1 << k);
      if (p >= 1 && k < 16) begin
        rdy = 16'(1 << k);
        vx  = 4'(k);
        vy  = 4'(p - 1);
      end
      cs = (n >= 256);
      bz = 1;
    end else if (n >= 4096 && n < 4112) begin
      c   = n - 4096;
      s2  = 10'(30 * 32 + 16 + c);
      rdy = 16'(1 << c);
      vx  = 4'(c);
      vy  = 4'd15;
      cs  = 1;
      bz  = 1;
    end else if (n == 4112) begin
      dn = 1;
    end
    return {ar, s1, s2, mux, nd, rdy, cs, vx, vy, bz, dn};
  endfunction

  task automatic test_reset();
    logic [86:0] e;
    logic [86:0] a;
    rst = 1'b1;
    bus.start = 1'b0;
    sb_q.push_back(87'd0);
    step();
    step();
    e = sb_q.pop_front();
    a = obs();
    n_chk++;
    if (a !== e) $display("FAIL reset_outputs got %h want %h", a, e);
    else n_pass++;
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b00)
      $display("FAIL reset_status got %b want 00", {bus.busy, bus.done});
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_search();
    logic [86:0] e;
    logic [86:0] a;
    int pulses = 0;
    int done_at = -1;
    int multi = 0;
    int nerr = 0;
    bus.start = 1'b1;
    sb_q.push_back(exp_at(0));
    step();
    bus.start = 1'b0;
    for (int n = 0; n < 4116; n++) begin
      e = sb_q.pop_front();
      a = obs();
      n_chk++;
      if (a !== e) begin
        nerr++;
        $display("FAIL cycle_%0d got %h want %h", n, a, e);
      end else n_pass++;
      pulses += $countones(bus.PEready);
      if ($countones(bus.PEready) > 1) multi++;
      if (bus.done === 1'b1 && done_at < 0) done_at = n;
      if (n == 0) begin
        n_chk++;
        if ({bus.AddressR, bus.NewDist, bus.S1S2mux, bus.PEready,
             bus.CompStart, bus.busy} !==
            {8'h00, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1})
          $display("FAIL cnt0 ar=%h nd=%h mux=%h rdy=%h cs=%b busy=%b",
                   bus.AddressR, bus.NewDist, bus.S1S2mux,
                   bus.PEready, bus.CompStart, bus.busy);
        else n_pass++;
      end
      if (n == 264) begin
        n_chk++;
        if ({bus.PEready, bus.VectorX, bus.VectorY, bus.CompStart,
             bus.AddressR} !==
            {16'h0100, 4'd8, 4'd0, 1'b1, 8'h08})
          $display("FAIL cnt264 rdy=%h vx=%0d vy=%0d cs=%b ar=%h",
                   bus.PEready, bus.VectorX, bus.VectorY,
                   bus.CompStart, bus.AddressR);
        else n_pass++;
      end
      if (n == 'h5A3) begin
        n_chk++;
        if ({bus.AddressR, bus.AddressS1, bus.AddressS2, bus.S1S2mux,
             bus.PEready} !==
            {8'hA3, 10'd483, 10'd467, 16'h000F, 16'h0000})
          $display("FAIL cnt5A3 ar=%h s1=%0d s2=%0d mux=%h rdy=%h",
                   bus.AddressR, bus.AddressS1, bus.AddressS2,
                   bus.S1S2mux, bus.PEready);
        else n_pass++;
      end
      if (n == 'h503) begin
        n_chk++;
        if ({bus.PEready, bus.VectorX, bus.VectorY, bus.NewDist} !==
            {16'h0008, 4'd3, 4'd4, 16'h0008})
          $display("FAIL cnt503 rdy=%h vx=%0d vy=%0d nd=%h",
                   bus.PEready, bus.VectorX, bus.VectorY, bus.NewDist);
        else n_pass++;
      end
      if (n == 4110) begin
        n_chk++;
        if ({bus.PEready, bus.VectorX, bus.VectorY, bus.NewDist,
             bus.S1S2mux, bus.AddressS2} !==
            {16'h4000, 4'd14, 4'd15, 16'h0000, 16'h0000, 10'd990})
          $display("FAIL cnt4110 rdy=%h vx=%0d vy=%0d nd=%h mux=%h s2=%0d",
                   bus.PEready, bus.VectorX, bus.VectorY,
                   bus.NewDist, bus.S1S2mux, bus.AddressS2);
        else n_pass++;
      end
      if (n == 4113) begin
        n_chk++;
        if ({bus.busy, bus.done} !== 2'b00)
          $display("FAIL after_done got %b want 00", {bus.busy, bus.done});
        else n_pass++;
      end
      if (nerr > 20) break;
      // start while busy or in DONE must be ignored
      bus.start = (n == 500 || n == 501 || n == 4100 || n == 4112);
      if (n < 4115) sb_q.push_back(exp_at(n + 1));
      step();
    end
    bus.start = 1'b0;
    sb_q.delete();
    n_chk++;
    if (pulses !== 256) $display("FAIL pe_pulses got %0d want 256", pulses);
    else n_pass++;
    n_chk++;
    if (multi !== 0) $display("FAIL pe_onehot got %0d want 0", multi);
    else n_pass++;
    n_chk++;
    if (done_at !== 4112)
      $display("FAIL done_latency got %0d want 4112", done_at);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [86:0] e;
    logic [86:0] a;
    int seen = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      bus.start = (n >= 10 && n <= 20);
      step();
    end
    bus.start = 1'b0;
    sb_q.push_back(exp_at(1000));
    e = sb_q.pop_front();
    a = obs();
    n_chk++;
    if (a !== e) $display("FAIL cnt1000 got %h want %h", a, e);
    else n_pass++;
    rst = 1'b1;
    bus.start = 1'b1;
    sb_q.push_back(87'd0);
    step();
    e = sb_q.pop_front();
    a = obs();
    n_chk++;
    if (a !== e) $display("FAIL abort_idle got %h want %h", a, e);
    else n_pass++;
    sb_q.push_back(87'd0);
    step();
    e = sb_q.pop_front();
    a = obs();
    n_chk++;
    if (a !== e) $display("FAIL reset_over_start got %h want %h", a, e);
    else n_pass++;
    rst = 1'b0;
    bus.start = 1'b0;
    for (int n = 0; n < 4200; n++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    n_chk++;
    if (seen !== 0) $display("FAIL no_done_after_abort got %0d want 0", seen);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      int lat = -1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int n = 0; n < 5000; n++) begin
        if (bus.done === 1'b1) begin
          lat = n;
          break;
        end
        step();
      end
      n_chk++;
      if (lat !== 4112)
        $display("FAIL b2b_latency_%0d got %0d want 4112", s, lat);
      else n_pass++;
      step();
      n_chk++;
      if ({bus.busy, bus.done} !== 2'b00)
        $display("FAIL b2b_idle_%0d got %b want 00", s, {bus.busy, bus.done});
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    test_reset();
    test_full_search();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
